pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage core. It merges stall requests from IF, ID, EX (multi-cycle divider) and MEM into the 6-bit stall vector consumed by pc_reg and the inter-stage registers. It detects exceptions/ERET reported by MEM and drives a flush pulse with the redirect PC. It also keeps stall-cycle statistics and a stall watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl_exc_vec_decode.sv | 30 +++
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall encodings,
// exception codes, hold/release levels and the FSM state codes.
package pipe_ctrl_pkg;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // Stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
   localparam logic [31:0] EXC_INT          = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
   localparam logic [31:0] EXC_BREAK        = 32'h0000_0009;
   localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
   localparam logic [31:0] EXC_OV           = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   // The deepest stalled stage wins, since it freezes everything before it.
   function automatic logic [5:0] stallEncode(input logic ifReq, input logic idReq,
                                              input logic exReq, input logic memReq);
      logic [5:0] v;
      v = STALL_NONE;
      if (memReq == STOP)      v = STALL_MEM;
      else if (exReq == STOP)  v = STALL_EX;
      else if (idReq == STOP)  v = STALL_ID;
      else if (ifReq == STOP)  v = STALL_IF;
      return v;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and the sequencer. The master side
// raises requests and exceptions; the slave side (the sequencer) answers
// with the stall vector, flush/redirect and statistics.
interface pipe_ctrl_if;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles;
   logic        stall_timeout;

   modport master (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
             excepttype_i, cp0_epc_i,
      input  stall, flush, new_pc, stall_cycles, stall_timeout
   );

   modport slave (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
             excepttype_i, cp0_epc_i,
      output stall, flush, new_pc, stall_cycles, stall_timeout
   );
endinterface

// File: rtl/pipe_ctrl_exc_vec_decode.sv
// Maps the exception code reported by MEM to the redirect target.
// ERET returns to the saved EPC; interrupts have their own vector.
module exc_vec_decode
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
   parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
   input  logic [31:0] i_excepttype,
   input  logic [31:0] i_epc,
   output logic [31:0] o_newPc
);

   // Pure lookup; unknown nonzero codes are treated as ordinary exceptions.
   always_comb begin
      o_newPc = EXC_VECTOR;
      case (i_excepttype)
         EXC_NONE:         o_newPc = 32'h0000_0000;
         EXC_INT:          o_newPc = INT_VECTOR;
         EXC_SYSCALL,
         EXC_BREAK,
         EXC_INST_INVALID,
         EXC_OV,
         EXC_TRAP:         o_newPc = EXC_VECTOR;
         EXC_ERET:         o_newPc = i_epc;
         default:          o_newPc = EXC_VECTOR;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests into the stall vector,
// turns MEM exceptions into a flush pulse with redirect PC, and keeps
// stall statistics plus a sticky stall watchdog.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
   parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
   parameter int          FLUSH_CYCLES  = 1,
   parameter int          STALL_TIMEOUT = 1024
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);

   localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [31:0] TIMEOUT    = 32'(STALL_TIMEOUT);
   localparam logic [31:0] TIMEOUT_M1 = 32'(STALL_TIMEOUT - 1);

   logic [0:0]  r_state;
   logic [3:0]  r_flushCnt;
   logic [31:0] r_newPc;
   logic [31:0] r_stallCycles;
   logic [31:0] r_runLen;
   logic        r_timeout;

   logic [31:0] w_decPc;
   logic [5:0]  w_stall;
   logic        w_flush;
   logic [31:0] w_newPc;

   exc_vec_decode #(
      .EXC_VECTOR (EXC_VECTOR),
      .INT_VECTOR (INT_VECTOR)
   ) u_dec (
      .i_excepttype (bus.excepttype_i),
      .i_epc        (bus.cp0_epc_i),
      .o_newPc      (w_decPc)
   );

   // Same-cycle outputs: reset and flush both force the stall vector off.
   always_comb begin
      w_stall = STALL_NONE;
      w_flush = 1'b0;
      w_newPc = 32'h0000_0000;
      if (!rst) begin
         w_stall = STALL_NONE;
      end else if (r_state == ST_FLUSH) begin
         w_flush = 1'b1;
         w_newPc = r_newPc;
      end else if (bus.excepttype_i != EXC_NONE) begin
         w_flush = 1'b1;
         w_newPc = w_decPc;
      end else begin
         w_stall = stallEncode(bus.stallreq_if, bus.stallreq_id,
                               bus.stallreq_ex, bus.stallreq_mem);
      end
   end

   // Stretch the flush when more than one cycle is needed; the target is latched on entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_RUN;
         r_flushCnt <= 4'd0;
         r_newPc    <= 32'h0000_0000;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_flush && (FLUSH_CYCLES > 1)) begin
                  r_state    <= ST_FLUSH;
                  r_flushCnt <= FLUSH_LOAD;
                  r_newPc    <= w_decPc;
               end
            end
            ST_FLUSH: begin
               r_flushCnt <= r_flushCnt - 4'd1;
               if (r_flushCnt <= 4'd1) begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   // Saturating count of every cycle the PC was held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stallCycles <= 32'h0000_0000;
      end else if ((w_stall[0] == STOP) && (r_stallCycles != 32'hFFFF_FFFF)) begin
         r_stallCycles <= r_stallCycles + 32'd1;
      end
   end

   // Watchdog: measure the current unbroken stall run and latch the flag once it is too long.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_runLen  <= 32'h0000_0000;
         r_timeout <= 1'b0;
      end else begin
         if (w_flush || (w_stall[0] == NO_STOP)) begin
            r_runLen <= 32'h0000_0000;
         end else if (r_runLen < TIMEOUT) begin
            r_runLen <= r_runLen + 32'd1;
         end
         if ((w_stall[0] == STOP) && !w_flush && (r_runLen == TIMEOUT_M1)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign bus.stall         = w_stall;
   assign bus.flush         = w_flush;
   assign bus.new_pc        = w_newPc;
   assign bus.stall_cycles  = r_stallCycles;
   assign bus.stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (FLUSH_CYCLES=3, STALL_TIMEOUT=8).
// Each stimulus cycle queues its hand-computed expectation; a monitor
// pops and compares mid-cycle, after the inputs settle.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam logic [3:0] R_NONE = 4'b0000;
   localparam logic [3:0] R_IF   = 4'b0001;
   localparam logic [3:0] R_ID   = 4'b0010;
   localparam logic [3:0] R_EX   = 4'b0100;
   localparam logic [3:0] R_MEM  = 4'b1000;

   typedef struct {
      string       name;
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic [31:0] sc;
      logic        to;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   pipe_ctrl_if bus();

   pipe_ctrl #(
      .EXC_VECTOR    (32'h0000_0040),
      .INT_VECTOR    (32'h0000_0020),
      .FLUSH_CYCLES  (3),
      .STALL_TIMEOUT (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s.%s got %h expected %h", name, field, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue its expectation.
   task automatic applyStimulus(input string name, input logic r, input logic [3:0] req,
                                input logic [31:0] exc, input logic [31:0] epc,
                                input logic [5:0] eStall, input logic eFlush,
                                input logic [31:0] ePc, input logic [31:0] eSc,
                                input logic eTo);
      exp_t e;
      @(negedge clk);
      rst              = r;
      bus.stallreq_if  = req[0];
      bus.stallreq_id  = req[1];
      bus.stallreq_ex  = req[2];
      bus.stallreq_mem = req[3];
      bus.excepttype_i = exc;
      bus.cp0_epc_i    = epc;
      e.name  = name;
      e.stall = eStall;
      e.flush = eFlush;
      e.pc    = ePc;
      e.sc    = eSc;
      e.to    = eTo;
      expQ.push_back(e);
   endtask

   // Exception cycle, two stretched flush cycles (with noise that must be ignored), then back to RUN.
   task automatic runException(input string name, input logic [31:0] exc, input logic [31:0] epc,
                               input logic [3:0] req, input logic [31:0] pc,
                               input logic [31:0] sc, input logic to);
      applyStimulus(name, 1'b1, req, exc, epc, STALL_NONE, 1'b1, pc, sc, to);
      applyStimulus({name, "_f1"}, 1'b1, R_MEM, 32'h0, 32'h0, STALL_NONE, 1'b1, pc, sc, to);
      applyStimulus({name, "_f2"}, 1'b1, R_ID, 32'h8, 32'h200, STALL_NONE, 1'b1, pc, sc, to);
      applyStimulus({name, "_run"}, 1'b1, R_NONE, 32'h0, 32'h0, STALL_NONE, 1'b0, 32'h0, sc, to);
   endtask

   // Monitor: compare each queued expectation two ns after the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.name, "stall", {26'h0, bus.stall}, {26'h0, e.stall});
            checkOutput(e.name, "flush", {31'h0, bus.flush}, {31'h0, e.flush});
            if (e.flush) checkOutput(e.name, "new_pc", bus.new_pc, e.pc);
            checkOutput(e.name, "stall_cycles", bus.stall_cycles, e.sc);
            checkOutput(e.name, "stall_timeout", {31'h0, bus.stall_timeout}, {31'h0, e.to});
         end
      end
   end

   // Hard time limit so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL global_timeout got running expected finished");
      $fatal(1, "[TB] simulation time limit");
   end

   // Directed stimulus sequence.
   initial begin
      bus.stallreq_if  = 1'b0;
      bus.stallreq_id  = 1'b0;
      bus.stallreq_ex  = 1'b0;
      bus.stallreq_mem = 1'b0;
      bus.excepttype_i = 32'h0;
      bus.cp0_epc_i    = 32'h0;

      applyStimulus("reset",    1'b0, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd0, 0);
      applyStimulus("idle",     1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd0, 0);
      applyStimulus("id_mem",   1'b1, R_ID | R_MEM, 0, 0, STALL_MEM, 0, 0, 32'd0, 0);
      applyStimulus("id_only",  1'b1, R_ID, 0, 0, STALL_ID, 0, 0, 32'd1, 0);
      applyStimulus("released", 1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd2, 0);
      applyStimulus("if_only",  1'b1, R_IF, 0, 0, STALL_IF, 0, 0, 32'd2, 0);
      applyStimulus("idle2",    1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd3, 0);

      applyStimulus("reset2",   1'b0, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd0, 0);
      applyStimulus("idle3",    1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd0, 0);
      for (int k = 0; k < 34; k++) begin
         applyStimulus("divider", 1'b1, R_EX, 0, 0, STALL_EX, 0, 0, 32'(k), (k >= 8));
      end
      applyStimulus("div_done", 1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd34, 1);

      runException("exc_ov",   32'hc, 32'h0,   R_EX,   32'h40,  32'd34, 1'b1);
      runException("eret",     32'he, 32'h100, R_NONE, 32'h100, 32'd34, 1'b1);
      runException("interrupt",32'h1, 32'h0,   R_MEM,  32'h20,  32'd34, 1'b1);
      runException("exc_other",32'h7, 32'h300, R_IF,   32'h40,  32'd34, 1'b1);

      applyStimulus("mid_flush_exc", 1'b1, R_NONE, 32'ha, 0, STALL_NONE, 1, 32'h40, 32'd34, 1);
      applyStimulus("mid_flush_f1",  1'b1, R_NONE, 0, 0, STALL_NONE, 1, 32'h40, 32'd34, 1);
      applyStimulus("mid_flush_rst", 1'b0, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd0, 0);
      applyStimulus("after_flush_rst", 1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd0, 0);

      for (int k = 0; k < 8; k++) begin
         applyStimulus("wd_mem", 1'b1, R_MEM, 0, 0, STALL_MEM, 0, 0, 32'(k), 0);
      end
      applyStimulus("wd_trip",   1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd8, 1);
      applyStimulus("wd_sticky", 1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd8, 1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus("wd_mem2", 1'b1, R_MEM, 0, 0, STALL_MEM, 0, 0, 32'(8 + k), 1);
      end
      applyStimulus("rst_mid_stall", 1'b0, R_MEM, 0, 0, STALL_NONE, 0, 0, 32'd0, 0);
      applyStimulus("after_stall_rst", 1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'd0, 0);

      #3;
      force dut.r_stallCycles = 32'hFFFF_FFFE;
      #1;
      release dut.r_stallCycles;
      applyStimulus("sat0", 1'b1, R_MEM, 0, 0, STALL_MEM, 0, 0, 32'hFFFF_FFFE, 0);
      applyStimulus("sat1", 1'b1, R_MEM, 0, 0, STALL_MEM, 0, 0, 32'hFFFF_FFFF, 0);
      applyStimulus("sat2", 1'b1, R_MEM, 0, 0, STALL_MEM, 0, 0, 32'hFFFF_FFFF, 0);
      applyStimulus("sat3", 1'b1, R_NONE, 0, 0, STALL_NONE, 0, 0, 32'hFFFF_FFFF, 0);

      repeat (2) @(negedge clk);
      #3;
      checkOutput("scoreboard", "pending", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
